fetch_stage: RTL and testbench



---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage_skid_buffer.sv | 70 +++++++
 rtl/fetch_stage.sv | 126 ++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared types for the LC-3b fetch front end: word type, fetch FSM states,
// output-register update selects and the sequential PC increment.
package fetch_stage_pkg;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } lc3b_fetch_state;

  // How the if_* output registers update on the next edge.
  typedef enum logic [1:0] {
    OUT_KEEP   = 2'd0,
    OUT_MEM    = 2'd1,
    OUT_BUF    = 2'd2,
    OUT_BUBBLE = 2'd3
  } fetch_out_sel_e;

  // Byte step between sequential LC-3b instructions; decode reuses it.
  localparam lc3b_word LC3B_PC_STEP = 16'd2;

  // Sequential increment; 16-bit modulo, so 16'hFFFE + 2 wraps to 16'h0000.
  function automatic lc3b_word pc_add(input lc3b_word pc, input lc3b_word step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory read port. Fetch is the master (issues read/address),
// the memory is the slave (returns a one-cycle resp with rdata).
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic     imem_read;
  lc3b_word imem_address;
  logic     imem_resp;
  lc3b_word imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_skid_buffer.sv
// One-entry skid buffer plus the if_* output registers. The buffer catches a
// response that arrives while decode is stalled; the output mux loads either
// fresh memory data or the buffered word.
module fetch_stage_skid_buffer
  import fetch_stage_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           capture_i,
  input  lc3b_word       rdata_i,
  input  fetch_out_sel_e out_sel_i,
  input  lc3b_word       out_pc_i,
  output logic           if_valid_o,
  output lc3b_word       if_ir_o,
  output lc3b_word       if_pc_o
);

  lc3b_word buf_q;
  logic     valid_q, valid_d;
  lc3b_word ir_q, ir_d;
  lc3b_word pc_q, pc_d;

  // Capture stalled response data; the word is simply ignored if squashed.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
    end else if (capture_i) begin
      buf_q <= rdata_i;
    end
  end

  // Next value of the output registers from the FSM's select.
  always_comb begin
    valid_d = valid_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (out_sel_i)
      OUT_MEM: begin
        valid_d = 1'b1;
        ir_d    = rdata_i;
        pc_d    = out_pc_i;
      end
      OUT_BUF: begin
        valid_d = 1'b1;
        ir_d    = buf_q;
        pc_d    = out_pc_i;
      end
      OUT_BUBBLE: valid_d = 1'b0;
      default: ;
    endcase
  end

  // Output registers seen by decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

  assign if_valid_o = valid_q;
  assign if_ir_o    = ir_q;
  assign if_pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the fetch PC, issues one outstanding imem read at a
// time, squashes wrong-path fetches on a write-back redirect and feeds decode
// through a one-entry skid buffer.
//
// state   | meaning
// --------+----------------------------------------------------------------
// FETCH   | request at pc outstanding; response goes to decode or buffer
// HOLD    | decode stalled with a buffered word; no request issued
// DISCARD | redirect arrived mid-request; wait out the squashed response
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter lc3b_word START_PC = 16'h0000,
  parameter lc3b_word PC_STEP  = LC3B_PC_STEP
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 branch_enable_i,
  input  lc3b_word             branch_target_i,
  input  logic                 stall_i,
  fetch_stage_if.master        imem_if,
  output logic                 if_valid_o,
  output lc3b_word             if_ir_o,
  output lc3b_word             if_pc_o
);

  lc3b_fetch_state state_q, state_d;
  lc3b_word        pc_q, pc_d;
  lc3b_word        tgt_q, tgt_d;
  lc3b_word        pc_plus;
  logic            read_req;
  logic            capture;
  fetch_out_sel_e  out_sel;
  lc3b_word        out_pc;

  assign pc_plus = pc_add(pc_q, PC_STEP);

  // State, PC and pending-redirect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= START_PC;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next state and datapath controls; redirect outranks response outranks stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    read_req = 1'b0;
    capture  = 1'b0;
    out_sel  = OUT_KEEP;
    out_pc   = pc_plus;
    case (state_q)
      FETCH: begin
        read_req = 1'b1;
        if (branch_enable_i && imem_if.imem_resp) begin
          pc_d    = branch_target_i;
          out_sel = OUT_BUBBLE;
        end else if (branch_enable_i) begin
          tgt_d   = branch_target_i;
          out_sel = OUT_BUBBLE;
          state_d = DISCARD;
        end else if (imem_if.imem_resp && !stall_i) begin
          pc_d    = pc_plus;
          out_sel = OUT_MEM;
        end else if (imem_if.imem_resp) begin
          pc_d    = pc_plus;
          capture = 1'b1;
          state_d = HOLD;
        end else if (!stall_i) begin
          out_sel = OUT_BUBBLE;
        end
      end
      HOLD: begin
        // pc already points past the buffered word, so it is the word's if_pc.
        out_pc = pc_q;
        if (branch_enable_i) begin
          pc_d    = branch_target_i;
          out_sel = OUT_BUBBLE;
          state_d = FETCH;
        end else if (!stall_i) begin
          out_sel = OUT_BUF;
          state_d = FETCH;
        end
      end
      DISCARD: begin
        // Squashed request must stay on the bus unchanged until it completes.
        read_req = 1'b1;
        out_sel  = OUT_BUBBLE;
        if (branch_enable_i) begin
          tgt_d = branch_target_i;
        end
        if (imem_if.imem_resp) begin
          pc_d    = branch_enable_i ? branch_target_i : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem_if.imem_read    = read_req;
  assign imem_if.imem_address = pc_q;

  fetch_stage_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .capture_i  (capture),
    .rdata_i    (imem_if.imem_rdata),
    .out_sel_i  (out_sel),
    .out_pc_i   (out_pc),
    .if_valid_o (if_valid_o),
    .if_ir_o    (if_ir_o),
    .if_pc_o    (if_pc_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall/skid, redirect
// squash in flight, repeated redirects, redirect vs stall, PC wrap, reset.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic     clk;
  logic     reset;
  logic     branch_enable;
  lc3b_word branch_target;
  logic     stall;
  logic     if_valid;
  lc3b_word if_ir;
  lc3b_word if_pc;

  int checks = 0;
  int errors = 0;

  fetch_stage_if imem ();

  fetch_stage #(.START_PC(16'h0000), .PC_STEP(16'd2)) dut (
    .clk             (clk),
    .reset           (reset),
    .branch_enable_i (branch_enable),
    .branch_target_i (branch_target),
    .stall_i         (stall),
    .imem_if         (imem.master),
    .if_valid_o      (if_valid),
    .if_ir_o         (if_ir),
    .if_pc_o         (if_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    branch_enable = 1'b0;
    branch_target = 16'h0000;
    stall = 1'b0;
    imem.imem_resp = 1'b0;
    imem.imem_rdata = 16'h0000;
    step();
    step();
    chk("rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("rst_ir", if_ir, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
    chk("rst_addr", imem.imem_address, 16'h0000);
    chk("rst_read", {15'd0, imem.imem_read}, 16'h0001);
    reset = 1'b0;

    // Sequential fetch with single-cycle memory.
    imem.imem_resp = 1'b1; imem.imem_rdata = 16'h1234;
    step();
    chk("seq1_ir", if_ir, 16'h1234);
    chk("seq1_pc", if_pc, 16'h0002);
    chk("seq1_valid", {15'd0, if_valid}, 16'h0001);
    chk("seq1_addr", imem.imem_address, 16'h0002);
    imem.imem_rdata = 16'h5678;
    step();
    chk("seq2_ir", if_ir, 16'h5678);
    chk("seq2_pc", if_pc, 16'h0004);
    chk("seq2_addr", imem.imem_address, 16'h0004);

    // Response for 0x0004 lands while decode stalls for 3 cycles.
    imem.imem_rdata = 16'hABCD; stall = 1'b1;
    step();
    imem.imem_resp = 1'b0;
    chk("hold_read", {15'd0, imem.imem_read}, 16'h0000);
    chk("hold_ir", if_ir, 16'h5678);
    chk("hold_pc", if_pc, 16'h0004);
    chk("hold_valid", {15'd0, if_valid}, 16'h0001);
    step();
    step();
    chk("hold3_read", {15'd0, imem.imem_read}, 16'h0000);
    chk("hold3_ir", if_ir, 16'h5678);
    stall = 1'b0;
    step();
    chk("unst_ir", if_ir, 16'hABCD);
    chk("unst_pc", if_pc, 16'h0006);
    chk("unst_valid", {15'd0, if_valid}, 16'h0001);
    chk("unst_addr", imem.imem_address, 16'h0006);
    chk("unst_read", {15'd0, imem.imem_read}, 16'h0001);

    // Fetch 0x0006, then a slow request at 0x0008 squashed by a redirect.
    imem.imem_resp = 1'b1; imem.imem_rdata = 16'h1111;
    step();
    imem.imem_resp = 1'b0;
    chk("pre_ir", if_ir, 16'h1111);
    chk("pre_addr", imem.imem_address, 16'h0008);
    step();
    chk("bubble_valid", {15'd0, if_valid}, 16'h0000);
    branch_enable = 1'b1; branch_target = 16'h0100;
    step();
    branch_enable = 1'b0;
    chk("disc_addr", imem.imem_address, 16'h0008);
    chk("disc_read", {15'd0, imem.imem_read}, 16'h0001);
    step();
    chk("disc_addr2", imem.imem_address, 16'h0008);
    imem.imem_resp = 1'b1; imem.imem_rdata = 16'hDEAD;
    step();
    imem.imem_resp = 1'b0;
    chk("redir_addr", imem.imem_address, 16'h0100);
    chk("redir_valid", {15'd0, if_valid}, 16'h0000);
    chk("redir_ir_kept", if_ir, 16'h1111);

    // Two redirects while discarding; the later one wins.
    imem.imem_resp = 1'b1; imem.imem_rdata = 16'h2222;
    step();
    imem.imem_resp = 1'b0;
    chk("f100_ir", if_ir, 16'h2222);
    chk("f100_pc", if_pc, 16'h0102);
    branch_enable = 1'b1; branch_target = 16'h0100;
    step();
    chk("dd_addr1", imem.imem_address, 16'h0102);
    branch_target = 16'h0200;
    step();
    chk("dd_addr2", imem.imem_address, 16'h0102);
    branch_enable = 1'b0; imem.imem_resp = 1'b1; imem.imem_rdata = 16'hBAD0;
    step();
    chk("dd_addr", imem.imem_address, 16'h0200);
    chk("dd_valid", {15'd0, if_valid}, 16'h0000);

    // Redirect coincides with response under stall in FETCH.
    imem.imem_rdata = 16'h3333;
    step();
    chk("f200_ir", if_ir, 16'h3333);
    branch_enable = 1'b1; branch_target = 16'h0400; stall = 1'b1; imem.imem_rdata = 16'hBEEF;
    step();
    branch_enable = 1'b0;
    chk("brs_addr", imem.imem_address, 16'h0400);
    chk("brs_valid", {15'd0, if_valid}, 16'h0000);
    chk("brs_ir", if_ir, 16'h3333);
    chk("brs_read", {15'd0, imem.imem_read}, 16'h0001);

    // Redirect while HOLD discards the buffered word.
    imem.imem_rdata = 16'h4444;
    step();
    imem.imem_resp = 1'b0;
    chk("h2_read", {15'd0, imem.imem_read}, 16'h0000);
    branch_enable = 1'b1; branch_target = 16'h0500;
    step();
    branch_enable = 1'b0; stall = 1'b0;
    chk("hb_addr", imem.imem_address, 16'h0500);
    chk("hb_valid", {15'd0, if_valid}, 16'h0000);
    chk("hb_read", {15'd0, imem.imem_read}, 16'h0001);
    imem.imem_resp = 1'b1; imem.imem_rdata = 16'h5555;
    step();
    chk("hb_ir", if_ir, 16'h5555);
    chk("hb_pc", if_pc, 16'h0502);

    // PC wrap at 16'hFFFE.
    branch_enable = 1'b1; branch_target = 16'hFFFE; imem.imem_rdata = 16'h0000;
    step();
    branch_enable = 1'b0;
    chk("wrap_req", imem.imem_address, 16'hFFFE);
    imem.imem_rdata = 16'h6666;
    step();
    chk("wrap_ir", if_ir, 16'h6666);
    chk("wrap_pc", if_pc, 16'h0000);
    chk("wrap_addr", imem.imem_address, 16'h0000);
    imem.imem_rdata = 16'h7777;
    step();
    imem.imem_resp = 1'b0;
    chk("post_wrap_addr", imem.imem_address, 16'h0002);

    // Reset taken in DISCARD.
    branch_enable = 1'b1; branch_target = 16'h0700;
    step();
    branch_enable = 1'b0;
    chk("rd_addr", imem.imem_address, 16'h0002);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rd_rst_addr", imem.imem_address, 16'h0000);
    chk("rd_rst_read", {15'd0, imem.imem_read}, 16'h0001);
    chk("rd_rst_valid", {15'd0, if_valid}, 16'h0000);
    chk("rd_rst_ir", if_ir, 16'h0000);
    imem.imem_resp = 1'b1; imem.imem_rdata = 16'h8888;
    step();
    imem.imem_resp = 1'b0;
    chk("rd_fetch_ir", if_ir, 16'h8888);
    chk("rd_fetch_pc", if_pc, 16'h0002);
    chk("rd_fetch_valid", {15'd0, if_valid}, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
